// File: rtl/nibble_serial_adder_if.sv
// Operand/result handshake bundle for nibble_serial_adder.
// in_valid/in_ready and out_valid/out_ready are strict valid/ready: a transfer happens on the rising edge where both are high; the source holds payload stable while valid is high and not yet accepted.
interface nibble_serial_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] S;
  logic             cout;
  logic             ovf;
  logic             prop;

  modport master (
    output in_valid, A, B, cin, out_ready,
    input  in_ready, out_valid, S, cout, ovf, prop
  );

  modport slave (
    input  in_valid, A, B, cin, out_ready,
    output in_ready, out_valid, S, cout, ovf, prop
  );
endinterface

// File: rtl/nibble_serial_adder.sv
// Multi-word adder that walks a WIDTH-bit operand pair through one 4-bit
// carry-lookahead adder, one nibble per cycle, with a registered nibble carry.
module carrylookahead_adder (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       cin,
  output logic [3:0] S,
  output logic       cout,
  output logic       p,
  output logic       g
);
  logic [3:0] gi;
  logic [3:0] pi;
  logic [4:0] c;

  assign gi = A & B;
  assign pi = A ^ B;

  assign c[0] = cin;
  assign c[1] = gi[0] | (pi[0] & cin);
  assign c[2] = gi[1] | (pi[1] & gi[0]) | (pi[1] & pi[0] & cin);
  assign c[3] = gi[2] | (pi[2] & gi[1]) | (pi[2] & pi[1] & gi[0])
              | (pi[2] & pi[1] & pi[0] & cin);
  assign c[4] = gi[3] | (pi[3] & gi[2]) | (pi[3] & pi[2] & gi[1])
              | (pi[3] & pi[2] & pi[1] & gi[0])
              | (pi[3] & pi[2] & pi[1] & pi[0] & cin);

  assign S    = pi ^ c[3:0];
  assign cout = c[4];
  assign p    = &pi;
  assign g    = gi[3] | (pi[3] & gi[2]) | (pi[3] & pi[2] & gi[1])
              | (pi[3] & pi[2] & pi[1] & gi[0]);
endmodule

module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  nibble_serial_adder_if.slave bus,
  output logic [1:0]           state_o
);
  localparam int NIB = WIDTH / 4;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIB - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             prop_q, prop_d;
  logic [IW-1:0]    idx_q, idx_d;

  logic [3:0] nib_a, nib_b, cla_s;
  logic       cla_cout, cla_p, cla_g;

  always_comb begin
    nib_a = '0;
    nib_b = '0;
    for (int i = 0; i < NIB; i++) begin
      if (idx_q == IW'(i)) begin
        nib_a = a_q[4*i +: 4];
        nib_b = b_q[4*i +: 4];
      end
    end
  end

  carrylookahead_adder u_cla (
    .A   (nib_a),
    .B   (nib_b),
    .cin (carry_q),
    .S   (cla_s),
    .cout(cla_cout),
    .p   (cla_p),
    .g   (cla_g)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    prop_d  = prop_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.A;
          b_d     = bus.B;
          carry_d = bus.cin;
          idx_d   = '0;
          prop_d  = 1'b1;
          s_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int i = 0; i < NIB; i++) begin
          if (idx_q == IW'(i)) s_d[4*i +: 4] = cla_s;
        end
        // Group generate/propagate form of the nibble carry (same value as cout).
        carry_d = cla_g | (cla_p & carry_q);
        prop_d  = prop_q & cla_p;
        if (idx_q == LAST) begin
          cout_d  = cla_cout;
          ovf_d   = a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ cla_s[3] ^ cla_cout;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      prop_q  <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      prop_q  <= prop_d;
      idx_q   <= idx_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.S         = s_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
  assign bus.prop      = prop_q;
  assign state_o       = state_q;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder: driver pushes expected results,
// a negedge monitor pops and compares on each output handshake.
module tb_nibble_serial_adder;
  localparam int W  = 16;
  localparam int EW = W + 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] state_dbg;

  int errors = 0;
  int checks = 0;

  logic [EW-1:0] exp_q[$];

  nibble_serial_adder_if #(.WIDTH(W)) bus ();

  nibble_serial_adder #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus),
    .state_o(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // driver: wait for in_ready, present one operand pair for one accept edge
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                      input logic [W-1:0] es, input logic ec, input logic eo,
                      input logic ep);
    int n = 0;
    while (bus.in_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) chk("send_wait_in_ready", 32'(bus.in_ready), 32'd1);
    bus.A        = a;
    bus.B        = b;
    bus.cin      = c;
    bus.in_valid = 1'b1;
    exp_q.push_back({es, ec, eo, ep});
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || bus.out_valid !== 1'b0) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      logic [EW-1:0] act;
      act = {bus.S, bus.cout, bus.ovf, bus.prop};
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 32'(act), 32'h7FFFFFFF);
      end else begin
        chk("result_S_cout_ovf_prop", 32'(act), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.A         = '0;
    bus.B         = '0;
    bus.cin       = 1'b0;

    // 1: reset with random inputs
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.A        = 16'($urandom_range(0, 16'hFFFF));
      bus.B        = 16'($urandom_range(0, 16'hFFFF));
      bus.cin      = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("rst_S", 32'(bus.S), 32'd0);
      chk("rst_flags", {29'd0, bus.cout, bus.ovf, bus.prop}, 32'd0);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    rst_n        = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      chk("post_rst_state", 32'(state_dbg), 32'd0);
      chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    end

    // 2: basic add with latency check
    send(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      chk("latency_out_valid", 32'(bus.out_valid), (k == 4) ? 32'd1 : 32'd0);
    end
    wait_drain();

    // 3, 4: carry ripple and overflow
    send(16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
    wait_drain();
    send(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
    wait_drain();
    send(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
    wait_drain();

    // 5: back-pressure with ignored input pulses during RUN and DONE
    bus.out_ready = 1'b0;
    send(16'h00FF, 16'h0F01, 1'b1, 16'h1001, 1'b0, 1'b0, 1'b0);
    bus.A        = 16'hFFFF;
    bus.B        = 16'hFFFF;
    bus.in_valid = 1'b1;
    begin
      int n = 0;
      while (bus.out_valid !== 1'b1 && n < 20) begin
        @(posedge clk); #1;
        n++;
      end
      chk("bp_out_valid_rise", 32'(bus.out_valid), 32'd1);
    end
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = i[0];
      bus.A        = 16'(16'hA5A5 + i);
      @(posedge clk); #1;
      chk("bp_hold_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_hold_in_ready", 32'(bus.in_ready), 32'd0);
      chk("bp_hold_S", 32'(bus.S), 32'h1001);
      chk("bp_hold_flags", {29'd0, bus.cout, bus.ovf, bus.prop}, 32'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_out_valid", 32'(bus.out_valid), 32'd0);
    chk("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
    chk("bp_queue_empty", 32'(exp_q.size()), 32'd0);

    // 6: asynchronous reset mid-RUN, then a clean operation
    bus.A        = 16'hABCD;
    bus.B        = 16'h1111;
    bus.cin      = 1'b0;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("midrst_S", 32'(bus.S), 32'd0);
    chk("midrst_state", 32'(state_dbg), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0);
    wait_drain();
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
